// File: rtl/frame_pkg.sv
// Shared types and defaults for the UART-to-frame-buffer write path.
// Holds the FSM state encoding, default geometry/timing and a width helper.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_ADDR_W         = 19;
  localparam int DEF_FRAME_PIXELS   = 307200;
  localparam int DEF_TIMEOUT_CYCLES = 5000000;
  localparam int DEF_ERR_W          = 8;

  // clocks per UART bit at 115200 baud from 50 MHz
  localparam int BIT_CLKS = 434;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle timeout counter: clear loads zero, enable counts, tc flags the
// terminal count (TIMEOUT_CYCLES-1) while enabled.
// Ports: clk, rst (sync, high), clear, enable -> tc.
module idle_timer
  import frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // holds at the terminal value so it can never roll over
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign tc = enable && (count == LAST);

endmodule

// File: rtl/uart_frame_writer.sv
// Turns a UART byte stream into one frame of sequential BRAM writes,
// with ready/ack frame handoff, idle abort and framing-error counting.
// Ports: clk, rst, rx_valid/rx_data/rx_frame_error, frame_ack ->
//        wr_en/wr_addr/wr_data, busy, frame_ready, timeout_abort, err_count.
module uart_frame_writer
  import frame_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int FRAME_PIXELS   = DEF_FRAME_PIXELS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ERR_W          = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_frame_error,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_ready,
  output logic              timeout_abort,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              wr_n;
  logic              abort_n;
  logic              accept;
  logic              bad;
  logic              tc;

  assign accept = rx_valid && !rx_frame_error;
  assign bad    = rx_valid && rx_frame_error;

  // error bytes fall through to "count", so they never restart the timer
  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept || state != RECV),
    .enable(state == RECV),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    wr_n    = 1'b0;
    abort_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          wr_n = 1'b1;
          if (FRAME_PIXELS == 1) begin
            state_n = DONE;
          end else begin
            state_n = RECV;
            ptr_n   = ADDR_W'(1);
          end
        end
      end
      RECV: begin
        if (accept) begin
          wr_n = 1'b1;
          if (ptr == LAST) begin
            state_n = DONE;
            ptr_n   = '0;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end else if (tc) begin
          abort_n = 1'b1;
          state_n = IDLE;
          ptr_n   = '0;
        end
      end
      DONE: begin
        if (frame_ack) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        ptr_n   = '0;
      end
    endcase
  end

  // frame_ready trails entry to DONE by a cycle but drops right after ack
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      frame_ready   <= 1'b0;
      timeout_abort <= 1'b0;
      err_count     <= '0;
    end else begin
      wr_en         <= wr_n;
      busy          <= (state_n == RECV);
      frame_ready   <= (state == DONE) && !frame_ack;
      timeout_abort <= abort_n;
      if (wr_n) begin
        wr_addr <= ptr;
        wr_data <= rx_data;
      end
      if (bad && err_count != '1) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_writer.sv
// Self-checking bench for uart_frame_writer (4-byte frames, 100-clock timeout).
// Directed table, timeout/saturation sequences, then a random run vs a model.
module tb_uart_frame_writer;

  localparam int AW = 8;
  localparam int FP = 4;
  localparam int TO = 100;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_frame_error = 1'b0;
  logic          frame_ack = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_ready;
  logic          timeout_abort;
  logic [EW-1:0] err_count;

  uart_frame_writer #(
    .ADDR_W        (AW),
    .FRAME_PIXELS  (FP),
    .TIMEOUT_CYCLES(TO),
    .ERR_W         (EW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_frame_error(rx_frame_error),
    .frame_ack     (frame_ack),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .frame_ready   (frame_ready),
    .timeout_abort (timeout_abort),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // apply inputs for one cycle, return 1 time unit after the edge
  task automatic drive(input bit r, input bit v, input bit fe,
                       input bit a, input logic [7:0] d);
    rst            = r;
    rx_valid       = v;
    rx_frame_error = fe;
    frame_ack      = a;
    rx_data        = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         r, v, fe, ack;
    logic [7:0] d;
    bit         wr;
    int         addr;
    bit         bsy, rdy, ab;
    int         err;
  } vec_t;

  vec_t tbl[$];

  // behavioural model: bytes held in the partial frame, frame-held flag,
  // idle clocks since the last stored byte
  int         m_fill, m_idle, m_err;
  bit         m_full;
  bit         e_wr, e_busy, e_rdy, e_ab;
  int         e_addr;
  logic [7:0] e_data;

  task automatic model(input bit r, input bit v, input bit fe,
                       input bit a, input logic [7:0] d);
    e_wr  = 0;
    e_ab  = 0;
    e_rdy = 0;
    if (r) begin
      m_fill = 0; m_idle = 0; m_err = 0; m_full = 0;
    end else begin
      if (v && fe && m_err < 255) m_err++;
      if (m_full) begin
        e_rdy = !a;
        if (a) m_full = 0;
      end else if (v && !fe) begin
        e_wr   = 1;
        e_addr = m_fill;
        e_data = d;
        m_fill++;
        m_idle = 0;
        if (m_fill == FP) begin
          m_fill = 0;
          m_full = 1;
        end
      end else if (m_fill > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          e_ab   = 1;
          m_fill = 0;
          m_idle = 0;
        end
      end
    end
    e_busy = (m_fill > 0) && !m_full;
  endtask

  initial begin
    int nwr;
    int quiet;
    bit r, v, fe, a;
    logic [7:0] d;

    //          r v fe ak  d      wr ad bs rd ab err
    tbl.push_back('{1,0,0,0, 8'h00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,1,0,0, 8'h10, 1, 0, 1, 0, 0, 0});
    tbl.push_back('{0,1,0,0, 8'h20, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{0,0,0,0, 8'h00, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0,1,1,0, 8'hEE, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{0,1,0,0, 8'h55, 1, 2, 1, 0, 0, 1});
    tbl.push_back('{0,1,0,0, 8'h04, 1, 3, 0, 0, 0, 1});
    tbl.push_back('{0,1,0,0, 8'h05, 0, 0, 0, 1, 0, 1});
    tbl.push_back('{0,0,0,0, 8'h00, 0, 0, 0, 1, 0, 1});
    tbl.push_back('{0,1,1,0, 8'h77, 0, 0, 0, 1, 0, 2});
    tbl.push_back('{0,0,0,1, 8'h00, 0, 0, 0, 0, 0, 2});
    tbl.push_back('{0,1,0,0, 8'hAA, 1, 0, 1, 0, 0, 2});
    tbl.push_back('{0,1,0,1, 8'hBB, 1, 1, 1, 0, 0, 2});
    tbl.push_back('{0,1,0,0, 8'hCC, 1, 2, 1, 0, 0, 2});
    tbl.push_back('{1,0,0,0, 8'h00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0,1,0,0, 8'hDD, 1, 0, 1, 0, 0, 0});
    tbl.push_back('{1,0,0,0, 8'h00, 0, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].fe, tbl[i].ack, tbl[i].d);
      chk($sformatf("tbl%0d wr_en", i), wr_en, tbl[i].wr);
      chk($sformatf("tbl%0d busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d frame_ready", i), frame_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d abort", i), timeout_abort, tbl[i].ab);
      chk($sformatf("tbl%0d err_count", i), err_count, tbl[i].err);
      if (tbl[i].wr) begin
        chk($sformatf("tbl%0d wr_addr", i), wr_addr, tbl[i].addr);
        chk($sformatf("tbl%0d wr_data", i), wr_data, tbl[i].d);
      end
    end

    // timeout: abort on the 100th idle clock after the last write pulse
    drive(0, 1, 0, 0, 8'h11);
    drive(0, 1, 0, 0, 8'h22);
    chk("to wr addr1", wr_addr, 1);
    for (int k = 1; k <= TO; k++) begin
      drive(0, 0, 0, 0, 8'h00);
      chk($sformatf("to abort k%0d", k), timeout_abort, (k == TO) ? 1 : 0);
      chk($sformatf("to busy k%0d", k), busy, (k < TO) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 8'h00);
    chk("to abort one pulse", timeout_abort, 0);
    drive(0, 1, 0, 0, 8'h33);
    chk("to resync wr_en", wr_en, 1);
    chk("to resync addr", wr_addr, 0);
    drive(1, 0, 0, 0, 8'h00);

    // byte on the terminal cycle wins over the abort
    drive(0, 1, 0, 0, 8'h44);
    drive(0, 1, 0, 0, 8'h45);
    for (int k = 1; k < TO; k++) begin
      drive(0, 0, 0, 0, 8'h00);
      chk($sformatf("term abort k%0d", k), timeout_abort, 0);
    end
    drive(0, 1, 0, 0, 8'h46);
    chk("term wr_en", wr_en, 1);
    chk("term addr", wr_addr, 2);
    chk("term data", wr_data, 8'h46);
    chk("term abort", timeout_abort, 0);
    drive(0, 0, 0, 0, 8'h00);
    chk("term abort next", timeout_abort, 0);
    chk("term busy", busy, 1);
    drive(1, 0, 0, 0, 8'h00);

    // error counter saturation, error bytes never written
    nwr = 0;
    for (int i = 1; i <= 300; i++) begin
      drive(0, 1, 1, 0, 8'hE0);
      if (wr_en) nwr++;
      if (i == 254) chk("sat 254", err_count, 254);
      if (i == 255) chk("sat 255", err_count, 255);
    end
    chk("sat final", err_count, 255);
    chk("sat no writes", nwr, 0);
    chk("sat busy", busy, 0);

    // random traffic against the model
    drive(1, 0, 0, 0, 8'h00);
    model(1, 0, 0, 0, 8'h00);
    quiet = 0;
    for (int i = 0; i < 6000; i++) begin
      if (quiet > 0) begin
        quiet--;
        v = 0;
      end else begin
        v = ($urandom % 3) == 0;
        if (($urandom % 120) == 0) quiet = $urandom_range(95, 105);
      end
      fe = v && (($urandom % 8) == 0);
      a  = ($urandom % 6) == 0;
      r  = ($urandom % 1500) == 0;
      d  = 8'($urandom);
      drive(r, v, fe, a, d);
      model(r, v, fe, a, d);
      chk("rnd wr_en", wr_en, e_wr);
      chk("rnd busy", busy, e_busy);
      chk("rnd frame_ready", frame_ready, e_rdy);
      chk("rnd abort", timeout_abort, e_ab);
      chk("rnd err_count", err_count, m_err);
      if (e_wr) begin
        chk("rnd wr_addr", wr_addr, e_addr);
        chk("rnd wr_data", wr_data, e_data);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
